mux_scan_sequencer: RTL and testbench
=====================================

Name: mux_scan_sequencer

Overview:
- Upstream control stage for the 4:1 bit multiplexer. Drives the mux `sel` port and reads back the mux `Out`.
- Steps `sel` through the enabled channels. Holds each channel for a programmable dwell time, then samples the mux output.
- Assembles the samples into a 4-bit snapshot and publishes it with a done pulse.
- Supports single-shot and continuous scanning under a start/stop handshake.

Parameters:
- DWELL, 4, cycles `sel` is held per channel before sampling; legal range 1..2^CNT_W-1.
- CNT_W, 8, width of the dwell counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a scan; sampled only in IDLE.
- cont  in  1  continuous mode; latched on an accepted start.
- stop  in  1  in continuous mode, finish the current scan and then go to IDLE.
- mask  in  4  channel enable bits; latched on an accepted start.
- mux_out  in  1  driven by the mux `Out`.
- sel  out  2  drives the mux `sel`.
- busy  out  1  high while scanning.
- done  out  1  one-cycle pulse when a scan completes.
- snap  out  4  last completed snapshot; bit i holds the sample of channel i.
- snap_valid  out  1  high once any scan has completed since reset.

Behaviour:
- Reset values (clk edge with rst=1): state=IDLE, sel=0, busy=0, done=0, snap=0, snap_valid=0, internal work register=0, dwell counter=0, mask_r=0, cont_r=0.
- rst has priority over every other input. Reset mid-scan aborts the scan with no done pulse and leaves snap=0.
- Two states: IDLE and SCAN. All outputs are registered; busy = (state==SCAN).
- IDLE, start=1 and mask!=0:
  - latch mask_r=mask and cont_r=cont;
  - clear the work register;
  - set sel = lowest set bit of mask and counter=0;
  - go to SCAN. sel is valid from the cycle after the start edge.
- IDLE, start=1 and mask==0: start is ignored. The block stays in IDLE with no busy and no done.
- SCAN:
  - counter increments each cycle.
  - On the edge where counter==DWELL-1: work[sel] is loaded with mux_out and counter is cleared.
  - If a higher enabled channel exists in mask_r, sel moves to the next higher enabled channel.
  - Otherwise end-of-scan occurs on that same edge:
    - snap loads work with the final sample merged in;
    - done=1 for exactly one cycle;
    - snap_valid=1;
    - work is cleared.
  - After end-of-scan: if cont_r=1, sel returns to the lowest enabled channel and the block stays in SCAN. Otherwise it goes to IDLE with sel=0.
- Disabled channels are never selected; their snap bits are always 0.
- Latency: with N enabled channels, done is high N*DWELL cycles after the start edge. sel changes only on dwell boundaries.
- start during SCAN is ignored. Changes to mask or cont during SCAN are ignored because the latched copies are used.
- stop=1 in any SCAN cycle clears cont_r. The current scan completes normally (done pulse, snap updated), then the block goes to IDLE.
- stop on the end-of-scan edge itself: this scan is the last one and the block goes to IDLE.
- stop in IDLE has no effect.
- start and stop both high in IDLE: the scan starts in single-shot mode.
- DWELL=1: sel advances every cycle and each channel is sampled on the edge after it is selected.

Optional Feature:
- Macro: SCAN_CHANGE_EN.
- Defined: adds output port `change` (1 bit, reset 0). `change` pulses together with done when the new snap differs from the previous snap value. The first scan after reset compares against 0.
- Undefined: the port and its comparison logic do not exist. All other behaviour is identical.

Test Plan:
- Setup for every scenario: the bench models the mux with In=4'b1010.
- DWELL=4, mask=1111, cont=0, start pulse -> sel=0,1,2,3 for 4 cycles each; done after 16 cycles; snap=1010; snap_valid=1; busy low the cycle after done; sel=0.
- mask=0101, In=1111 -> sel visits only 0 and 2; done after 8 cycles; snap=0101.
- mask=0000, start -> busy stays 0, done never asserted for 50 cycles; start during SCAN has no effect on sel sequence or done timing.
- cont=1, mask=1111:
  - first scan with In=1010 -> snap=1010;
  - In changed to 0110 -> second done yields 0110;
  - stop pulsed mid third scan -> third scan completes with done, then IDLE.
- rst=1 at cycle 6 of a scan -> next cycle all outputs zero, no done; a fresh start afterwards scans normally.
- With SCAN_CHANGE_EN: two consecutive scans of In=1010 -> change=1 on first done only; then In=0000 -> change=1 again on the next done.

Source files
------------

// File: rtl/mux_scan_sequencer.sv
// ============================================================================
// mux_scan_sequencer : steps a 4:1 mux select through enabled channels,
// samples each after DWELL cycles and publishes a 4-bit snapshot with done.
// Optional macro SCAN_CHANGE_EN adds a 'change' pulse output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux_scan_sequencer #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       stop,
  input  logic [3:0] mask,
  input  logic       mux_out,
  output logic [1:0] sel,
  output logic       busy,
  output logic       done,
  output logic [3:0] snap,
  output logic       snap_valid
`ifdef SCAN_CHANGE_EN
  ,
  output logic       change
`endif
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] C_DWELL_LAST = CNT_W'(DWELL - 1);

  state_t           r_state;
  logic [3:0]       r_work;
  logic [3:0]       r_mask;
  logic             r_cont;
  logic [CNT_W-1:0] r_cnt;

  logic             w_sample;
  logic             w_has_next;
  logic [1:0]       w_next;
  logic [3:0]       w_work_upd;

  function automatic logic [1:0] f_lowest(input logic [3:0] m);
    logic [1:0] v;
    v = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) v = 2'(i);
    end
    return v;
  endfunction

  // Returns {found, index} of the nearest enabled channel above s.
  function automatic logic [2:0] f_next_higher(input logic [3:0] m, input logic [1:0] s);
    logic [2:0] v;
    v = 3'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && (2'(i) > s)) v = {1'b1, 2'(i)};
    end
    return v;
  endfunction

  assign w_sample              = (r_cnt == C_DWELL_LAST);
  assign {w_has_next, w_next}  = f_next_higher(r_mask, sel);

  always_comb begin
    w_work_upd      = r_work;
    w_work_upd[sel] = mux_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      sel        <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      snap       <= 4'd0;
      snap_valid <= 1'b0;
      r_work     <= 4'd0;
      r_cnt      <= '0;
      r_mask     <= 4'd0;
      r_cont     <= 1'b0;
`ifdef SCAN_CHANGE_EN
      change     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SCAN_CHANGE_EN
      change <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (start && (mask != 4'd0)) begin
            r_mask  <= mask;
            r_cont  <= cont & ~stop;
            r_work  <= 4'd0;
            sel     <= f_lowest(mask);
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (stop) r_cont <= 1'b0;
          if (!w_sample) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_cnt <= '0;
            if (w_has_next) begin
              r_work <= w_work_upd;
              sel    <= w_next;
            end else begin
              // End of scan: the final sample is merged straight into snap.
              snap       <= w_work_upd;
              done       <= 1'b1;
              snap_valid <= 1'b1;
              r_work     <= 4'd0;
`ifdef SCAN_CHANGE_EN
              change     <= (w_work_upd != snap);
`endif
              if (r_cont && !stop) begin
                sel <= f_lowest(r_mask);
              end else begin
                sel     <= 2'd0;
                busy    <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux_scan_sequencer.sv
// ============================================================================
// tb_mux_scan_sequencer : scoreboard bench with a channel-list reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mux_scan_sequencer;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] mask = 4'd0;
  logic [3:0] mux_in = 4'b1010;
  logic       mux_out;
  logic [1:0] sel;
  logic       busy;
  logic       done;
  logic [3:0] snap;
  logic       snap_valid;
`ifdef SCAN_CHANGE_EN
  logic       change;
`endif

  assign mux_out = mux_in[sel];

  always #5 clk = ~clk;

  mux_scan_sequencer #(.DWELL(DWELL), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cont       (cont),
    .stop       (stop),
    .mask       (mask),
    .mux_out    (mux_out),
    .sel        (sel),
    .busy       (busy),
    .done       (done),
    .snap       (snap),
    .snap_valid (snap_valid)
`ifdef SCAN_CHANGE_EN
    ,
    .change     (change)
`endif
  );

  int n_checks = 0;
  int n_errs   = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a scan is the ordered list of enabled channels, each
  // held DWELL cycles; channel k of the list is sampled at edge (k+1)*DWELL.
  typedef struct {
    logic [3:0] snap;
    logic       chg;
  } exp_t;

  exp_t       sbq[$];
  bit         m_active = 1'b0;
  bit         m_cont   = 1'b0;
  bit         m_sv     = 1'b0;
  int         m_e      = 0;
  int         m_k      = 0;
  int         m_chans[$];
  logic [3:0] m_work   = 4'd0;
  logic [3:0] m_prev   = 4'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_sv     = 1'b0;
      m_prev   = 4'd0;
      m_work   = 4'd0;
      sbq.delete();
    end else if (m_active) begin
      m_e++;
      if (stop) m_cont = 1'b0;
      if (m_e % DWELL == 0) begin
        m_k = m_e / DWELL - 1;
        m_work[m_chans[m_k]] = mux_in[m_chans[m_k]];
        if (m_k == m_chans.size() - 1) begin
          sbq.push_back('{m_work, (m_work != m_prev)});
          m_prev = m_work;
          m_sv   = 1'b1;
          m_work = 4'd0;
          m_e    = 0;
          if (!m_cont) m_active = 1'b0;
        end
      end
    end else if (start && (mask != 4'd0)) begin
      m_active = 1'b1;
      m_e      = 0;
      m_cont   = cont && !stop;
      m_work   = 4'd0;
      m_chans.delete();
      for (int i = 0; i < 4; i++) if (mask[i]) m_chans.push_back(i);
    end
  end

  // Monitor: compares every cycle away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("busy", busy, m_active);
      chk("sel", sel, m_active ? m_chans[m_e / DWELL] : 0);
      chk("snap_valid", snap_valid, m_sv);
      if (done) begin
        n_checks++;
        if (sbq.size() == 0) begin
          n_errs++;
          $display("FAIL unexpected_done: got done=1 expected done=0 at %0t", $time);
        end else begin
          e = sbq.pop_front();
          chk("snap", snap, e.snap);
`ifdef SCAN_CHANGE_EN
          chk("change", change, e.chg);
`endif
        end
      end else begin
`ifdef SCAN_CHANGE_EN
        chk("change_idle", change, 1'b0);
`endif
        if (sbq.size() != 0) begin
          n_checks++;
          n_errs++;
          e = sbq.pop_front();
          $display("FAIL missing_done: got done=0 expected done=1 snap=%0h at %0t", e.snap, $time);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_start(input logic [3:0] m, input logic c);
    mask  = m;
    cont  = c;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      tick(1);
      if (done) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_errs++;
      $display("FAIL %s: got no done expected done within %0d cycles", nm, maxc);
    end
  endtask

  initial begin
    int dones;
    tick(1);
    mon_en = 1'b1;
    tick(2);
    chk("rst_done", done, 1'b0);
    chk("rst_snap", snap, 4'd0);
    rst = 1'b0;
    tick(1);

    // Full mask single shot: done exactly 16 cycles after the start edge
    mux_in = 4'b1010;
    do_start(4'b1111, 1'b0);
    tick(15);
    chk("lat16_early", done, 1'b0);
    tick(1);
    chk("lat16_done", done, 1'b1);
    chk("snap_1010", snap, 4'b1010);
    tick(1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_sel", sel, 2'd0);

    // Sparse mask: only channels 0 and 2
    mux_in = 4'b1111;
    do_start(4'b0101, 1'b0);
    tick(7);
    chk("lat8_early", done, 1'b0);
    tick(1);
    chk("lat8_done", done, 1'b1);
    chk("snap_0101", snap, 4'b0101);
    tick(2);

    // Empty mask is ignored
    do_start(4'b0000, 1'b0);
    dones = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (done || busy) dones++;
    end
    chk("empty_mask_activity", dones, 0);

    // start and mask changes mid-scan have no effect
    mux_in = 4'b1010;
    do_start(4'b1111, 1'b0);
    tick(5);
    mask  = 4'b0001;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(9);
    chk("restart_early", done, 1'b0);
    tick(1);
    chk("restart_done", done, 1'b1);
    tick(2);

    // Continuous mode, input change between scans, stop mid third scan
    mux_in = 4'b1010;
    do_start(4'b1111, 1'b1);
    wait_done(20, "cont_first");
    chk("cont_snap1", snap, 4'b1010);
    mux_in = 4'b0110;
    wait_done(20, "cont_second");
    chk("cont_snap2", snap, 4'b0110);
    tick(6);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    wait_done(20, "cont_third");
    tick(2);
    chk("stop_idle", busy, 1'b0);

    // Reset mid-scan aborts with no done
    mux_in = 4'b1010;
    do_start(4'b1111, 1'b0);
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort_sel", sel, 2'd0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_snap", snap, 4'd0);
    chk("abort_sv", snap_valid, 1'b0);
    tick(20);
    do_start(4'b0011, 1'b0);
    wait_done(12, "after_abort");
    chk("after_abort_snap", snap, 4'b0010);
    tick(2);

    // Randomized traffic with a per-cycle changing mux input
    for (int it = 0; it < 40; it++) begin
      mux_in = 4'($urandom);
      do_start(4'($urandom), 1'($urandom));
      for (int c = 0; c < int'($urandom_range(5, 60)); c++) begin
        mux_in = 4'($urandom);
        stop   = ($urandom % 16) == 0;
        start  = ($urandom % 8) == 0;
        mask   = 4'($urandom);
        cont   = 1'($urandom);
        tick(1);
      end
      start = 1'b0;
      stop  = 1'b1;
      for (int c = 0; c < 40 && busy; c++) tick(1);
      stop = 1'b0;
      chk("rand_drain", busy, 1'b0);
      tick(1);
    end

`ifdef SCAN_CHANGE_EN
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    mux_in = 4'b1010;
    do_start(4'b1111, 1'b0);
    wait_done(20, "chg_first");
    chk("chg_first", change, 1'b1);
    tick(1);
    do_start(4'b1111, 1'b0);
    wait_done(20, "chg_second");
    chk("chg_second", change, 1'b0);
    tick(1);
    mux_in = 4'b0000;
    do_start(4'b1111, 1'b0);
    wait_done(20, "chg_third");
    chk("chg_third", change, 1'b1);
`endif

    tick(3);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
